dma_desc_writer: RTL and testbench
==================================

# dma_desc_writer

Descriptor-table writer feeding the DMA engine: it takes descriptor requests from the host-side control logic, serializes each 96-bit descriptor into three 32-bit RAM writes, and lays them out in a ring at a programmable table base. It closes the ring with a LINK descriptor and, on the last descriptor of a chain, pulses the DMA's `command_reg_write` to start it. It is the producer of exactly the descriptor format the DMA fetch path consumes.

## Interface
- `TABLE_ENTRIES`, default 8: ring slots including the link slot; legal range ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `table_base`  in  64  byte address of slot 0; sampled whenever the slot address is formed.
- `desc_push`  in  1  request to append a descriptor; accepted only when `desc_ready`=1.
- `desc_address`  in  64  transfer address (descriptor bits [95:32]).
- `desc_length`  in  16  transfer length (bits [31:16]).
- `desc_int`  in  1  INT flag (bit 2).
- `desc_last`  in  1  END flag (bit 1); closes the chain and starts the DMA.
- `ram_busy`  in  1  RAM cannot accept a write this cycle.
- `desc_ready`  out  1  block idle and able to accept a push.
- `ram_write`  out  1  RAM write strobe.
- `ram_address`  out  64  RAM byte address.
- `data_to_ram`  out  32  RAM write data.
- `command_reg_write`  out  1  one-cycle DMA start pulse.
- `slot_index`  out  16  next ring slot to be written.

## Operation
- Descriptor layout: bits [95:32] address, [31:16] length, [15:6] 0, [5] ACT1, [4] ACT2, [3] 0, [2] INT, [1] END, [0] VALID.
- Data descriptor: ACT2=1, ACT1=0 (TRAN), VALID=1, INT/END from inputs. Low half-word = 0x0011 | INT<<2 | END<<1.
- Link descriptor: address = `table_base`, length 0, ACT2=1, ACT1=1, END=0, INT=0, VALID=1. Low word = 0x00000031.
- RAM word order: slot byte address A = `table_base` + 12·`slot_index` (64-bit, modulo 2^64). Word0 at A = desc[31:0], word1 at A+4 = desc[63:32], word2 at A+8 = desc[95:64].
- States:
  - IDLE: `desc_ready`=1. `desc_push` latches all fields and goes to W0.
  - W0, W1, W2: one word each. Advance only when `ram_busy`=0. After W2:
    - if END → START;
    - else if `slot_index`+1 = `TABLE_ENTRIES`-1 → L0;
    - else `slot_index`++ → IDLE.
  - L0, L1, L2: write the link descriptor to slot `TABLE_ENTRIES`-1, same stall rule. After L2, `slot_index`=0 → IDLE.
  - START: `command_reg_write`=1 for exactly one cycle, `slot_index`=0 → IDLE.
- `desc_last` takes precedence over link insertion. A last descriptor in slot `TABLE_ENTRIES`-2 writes no link.
- `desc_push` while `desc_ready`=0 is ignored; it is not queued.
- Registered outputs: `ram_write`, `ram_address` and `data_to_ram` are valid in the same cycle as the W/L state. While `ram_busy`=1 they hold stable with `ram_write` kept high.
- `ram_write`=0 and `data_to_ram`=0 in IDLE and START.
- Reset (async, any state, including mid-descriptor): state IDLE, `slot_index`=0, latched fields cleared, `ram_write`=0, `ram_address`=0, `data_to_ram`=0, `command_reg_write`=0, `desc_ready`=1 after deassertion. A partially written descriptor is abandoned, not completed.
- `TABLE_ENTRIES`=2: every non-last push is followed by a link write to slot 1.

## Timing
- Push accepted at edge N. Word0, word1 and word2 are presented in cycles N+1, N+2 and N+3 when `ram_busy`=0.
  - Normal case: `desc_ready` rises in N+4.
  - Link case: link words in N+4..N+6, ready in N+7.
  - Last case: `command_reg_write` high in N+4 only, ready in N+5.
- Each `ram_busy` cycle adds exactly one cycle of latency and causes no duplicate or skipped word.
- `desc_ready` is low from N+1 until return to IDLE.
- `command_reg_write` is never asserted in the same cycle as `ram_write`.

## Test plan
- Reset, `table_base`=0x1000, push {addr 0x2000, len 0x40, int 0, last 1} → writes 0x00400013@0x1000, 0x00002000@0x1004, 0x00000000@0x1008; `command_reg_write` pulse in cycle 4; `slot_index`=0.
- `TABLE_ENTRIES`=4, three non-last pushes → slots 0..2 written at 0x1000/0x100C/0x1018, then link 0x00000031@0x1024, 0x00001000@0x1028, 0x0@0x102C; `slot_index` returns to 0; no start pulse.
- Last push into slot 2 with `TABLE_ENTRIES`=4 → no link words; start pulse; `slot_index`=0.
- `ram_busy` high for 2 cycles during word1 → word1 address and data held 3 cycles; total latency 6; exactly 3 distinct writes.
- Assert `reset` during W1 → all outputs 0 immediately; next push writes slot 0 from word0.
- `desc_push` held high continuously → exactly one descriptor accepted per IDLE visit; intervening pushes dropped; `table_base`=0xFFFF_FFFF_FFFF_FFF8 with slot 1 → address wraps to 0x4.

Source files
------------

// File: rtl/dma_desc_writer.sv
// Descriptor-table writer: serializes 96-bit DMA descriptors into three 32-bit RAM
// writes laid out as a ring at table_base, closing the ring with a LINK descriptor.
module dma_desc_writer #(
  parameter int unsigned TABLE_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] table_base,
  input  logic        desc_push,
  input  logic [63:0] desc_address,
  input  logic [15:0] desc_length,
  input  logic        desc_int,
  input  logic        desc_last,
  input  logic        ram_busy,
  output logic        desc_ready,
  output logic        ram_write,
  output logic [63:0] ram_address,
  output logic [31:0] data_to_ram,
  output logic        command_reg_write,
  output logic [15:0] slot_index
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, L0, L1, L2, START} state_t;

  localparam logic [15:0] LINK_SLOT = 16'(TABLE_ENTRIES - 1);

  state_t      state, next_state;
  logic [63:0] lat_address;
  logic        lat_last;
  logic        nxt_write;
  logic [63:0] nxt_address;
  logic [31:0] nxt_data;
  logic [63:0] slot_base;
  logic [63:0] link_base;

  // 12 * slot computed as 8*slot + 4*slot; sums wrap modulo 2^64
  assign slot_base = table_base + ({48'b0, slot_index} << 3) + ({48'b0, slot_index} << 2);
  assign link_base = table_base + ({48'b0, LINK_SLOT} << 3) + ({48'b0, LINK_SLOT} << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (desc_push) next_state = W0;
      W0:    if (!ram_busy) next_state = W1;
      W1:    if (!ram_busy) next_state = W2;
      W2: begin
        if (!ram_busy) begin
          if (lat_last)                           next_state = START;
          else if (slot_index + 16'd1 == LINK_SLOT) next_state = L0;
          else                                    next_state = IDLE;
        end
      end
      L0:    if (!ram_busy) next_state = L1;
      L1:    if (!ram_busy) next_state = L2;
      L2:    if (!ram_busy) next_state = IDLE;
      START: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Word values are computed for the state being entered so the registered
  // outputs line up with that state; a stall re-registers the current word.
  always_comb begin
    desc_ready        = (state == IDLE);
    command_reg_write = (state == START);
    nxt_write         = 1'b0;
    nxt_address       = ram_address;
    nxt_data          = '0;
    if (next_state == state && state != IDLE && state != START) begin
      nxt_write = ram_write;
      nxt_data  = data_to_ram;
    end else begin
      case (next_state)
        W0: begin
          nxt_write   = 1'b1;
          nxt_address = slot_base;
          nxt_data    = {desc_length, 10'b0, 1'b0, 1'b1, 1'b0, desc_int, desc_last, 1'b1};
        end
        W1: begin
          nxt_write   = 1'b1;
          nxt_address = ram_address + 64'd4;
          nxt_data    = lat_address[31:0];
        end
        W2: begin
          nxt_write   = 1'b1;
          nxt_address = ram_address + 64'd4;
          nxt_data    = lat_address[63:32];
        end
        L0: begin
          nxt_write   = 1'b1;
          nxt_address = link_base;
          nxt_data    = 32'h0000_0031;
        end
        L1: begin
          nxt_write   = 1'b1;
          nxt_address = ram_address + 64'd4;
          nxt_data    = table_base[31:0];
        end
        L2: begin
          nxt_write   = 1'b1;
          nxt_address = ram_address + 64'd4;
          nxt_data    = table_base[63:32];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_address <= '0;
      lat_last    <= 1'b0;
      slot_index  <= '0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      data_to_ram <= '0;
    end else begin
      ram_write   <= nxt_write;
      ram_address <= nxt_address;
      data_to_ram <= nxt_data;
      if (state == IDLE && desc_push) begin
        lat_address <= desc_address;
        lat_last    <= desc_last;
      end
      if (state == W2 && next_state == IDLE)
        slot_index <= slot_index + 16'd1;
      else if ((state == L2 && next_state == IDLE) || state == START)
        slot_index <= '0;
    end
  end

endmodule

// File: tb/tb_dma_desc_writer.sv
// Directed bench for dma_desc_writer with a 4-slot ring; expected words are hand-computed.
module tb_dma_desc_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] table_base;
  logic        desc_push;
  logic [63:0] desc_address;
  logic [15:0] desc_length;
  logic        desc_int;
  logic        desc_last;
  logic        ram_busy;
  logic        desc_ready;
  logic        ram_write;
  logic [63:0] ram_address;
  logic [31:0] data_to_ram;
  logic        command_reg_write;
  logic [15:0] slot_index;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dma_desc_writer #(.TABLE_ENTRIES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .table_base        (table_base),
    .desc_push         (desc_push),
    .desc_address      (desc_address),
    .desc_length       (desc_length),
    .desc_int          (desc_int),
    .desc_last         (desc_last),
    .ram_busy          (ram_busy),
    .desc_ready        (desc_ready),
    .ram_write         (ram_write),
    .ram_address       (ram_address),
    .data_to_ram       (data_to_ram),
    .command_reg_write (command_reg_write),
    .slot_index        (slot_index)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag, input logic [63:0] a, input logic [31:0] d);
    check({tag, "_wr"},    64'(ram_write), 64'd1);
    check({tag, "_addr"},  ram_address, a);
    check({tag, "_data"},  64'(data_to_ram), 64'(d));
    check({tag, "_cmd"},   64'(command_reg_write), 64'd0);
    check({tag, "_ready"}, 64'(desc_ready), 64'd0);
  endtask

  task automatic idle(input string tag, input logic [15:0] slot);
    check({tag, "_wr"},    64'(ram_write), 64'd0);
    check({tag, "_data"},  64'(data_to_ram), 64'd0);
    check({tag, "_cmd"},   64'(command_reg_write), 64'd0);
    check({tag, "_ready"}, 64'(desc_ready), 64'd1);
    check({tag, "_slot"},  64'(slot_index), 64'(slot));
  endtask

  task automatic start_pulse(input string tag);
    check({tag, "_cmd"},   64'(command_reg_write), 64'd1);
    check({tag, "_wr"},    64'(ram_write), 64'd0);
    check({tag, "_data"},  64'(data_to_ram), 64'd0);
    check({tag, "_ready"}, 64'(desc_ready), 64'd0);
  endtask

  task automatic push(input logic [63:0] a, input logic [15:0] len, input logic i, input logic l);
    desc_address = a;
    desc_length  = len;
    desc_int     = i;
    desc_last    = l;
    desc_push    = 1'b1;
    tick();
    desc_push    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; table_base = 64'h1000; desc_push = 1'b0; desc_address = '0;
    desc_length = '0; desc_int = 1'b0; desc_last = 1'b0; ram_busy = 1'b0;
    tick(); tick();
    check("rst_addr", ram_address, 64'd0);
    idle("rst", 16'd0);
    reset = 1'b0;
    tick();

    // last descriptor: three words then start pulse in cycle 4
    push(64'h2000, 16'h40, 1'b0, 1'b1);
    show("t1w0", 64'h1000, 32'h0040_0013); tick();
    show("t1w1", 64'h1004, 32'h0000_2000); tick();
    show("t1w2", 64'h1008, 32'h0000_0000); tick();
    start_pulse("t1st"); tick();
    idle("t1end", 16'd0);

    // three non-last pushes, then link into slot 3
    push(64'h3000, 16'h10, 1'b0, 1'b0);
    show("t2s0w0", 64'h1000, 32'h0010_0011); tick();
    show("t2s0w1", 64'h1004, 32'h0000_3000); tick();
    show("t2s0w2", 64'h1008, 32'h0000_0000); tick();
    idle("t2s0", 16'd1);
    push(64'h3100, 16'h20, 1'b1, 1'b0);
    show("t2s1w0", 64'h100C, 32'h0020_0015); tick();
    show("t2s1w1", 64'h1010, 32'h0000_3100); tick();
    show("t2s1w2", 64'h1014, 32'h0000_0000); tick();
    idle("t2s1", 16'd2);
    push(64'h1_0000_3200, 16'h30, 1'b0, 1'b0);
    show("t2s2w0", 64'h1018, 32'h0030_0011); tick();
    show("t2s2w1", 64'h101C, 32'h0000_3200); tick();
    show("t2s2w2", 64'h1020, 32'h0000_0001); tick();
    show("t2l0",   64'h1024, 32'h0000_0031); tick();
    show("t2l1",   64'h1028, 32'h0000_1000); tick();
    show("t2l2",   64'h102C, 32'h0000_0000); tick();
    idle("t2end", 16'd0);

    // last descriptor in slot 2: no link, start pulse
    push(64'h4000, 16'h1, 1'b0, 1'b0);
    tick(); tick(); tick();
    idle("t3s0", 16'd1);
    push(64'h4100, 16'h2, 1'b0, 1'b0);
    tick(); tick(); tick();
    idle("t3s1", 16'd2);
    push(64'h4200, 16'h3, 1'b1, 1'b1);
    show("t3w0", 64'h1018, 32'h0003_0017); tick();
    show("t3w1", 64'h101C, 32'h0000_4200); tick();
    show("t3w2", 64'h1020, 32'h0000_0000); tick();
    start_pulse("t3st"); tick();
    idle("t3end", 16'd0);

    // two busy cycles during word1
    push(64'h5555_0000_AAAA_0000, 16'h100, 1'b1, 1'b0);
    show("t4w0", 64'h1000, 32'h0100_0015); tick();
    ram_busy = 1'b1;
    show("t4w1a", 64'h1004, 32'hAAAA_0000); tick();
    show("t4w1b", 64'h1004, 32'hAAAA_0000); tick();
    show("t4w1c", 64'h1004, 32'hAAAA_0000);
    ram_busy = 1'b0;
    tick();
    show("t4w2", 64'h1008, 32'h5555_0000); tick();
    idle("t4end", 16'd1);

    // reset in the middle of a descriptor
    push(64'h7777, 16'h7, 1'b0, 1'b0);
    show("t5w0", 64'h100C, 32'h0007_0011); tick();
    show("t5w1", 64'h1010, 32'h0000_7777);
    reset = 1'b1;
    #1;
    check("t5rst_addr", ram_address, 64'd0);
    idle("t5rst", 16'd0);
    tick();
    reset = 1'b0;
    tick();
    push(64'h8888, 16'h4, 1'b0, 1'b0);
    show("t5n0", 64'h1000, 32'h0004_0011); tick();
    show("t5n1", 64'h1004, 32'h0000_8888); tick();
    show("t5n2", 64'h1008, 32'h0000_0000); tick();
    idle("t5end", 16'd1);

    // push held high, base near the top of the address space
    table_base   = 64'hFFFF_FFFF_FFFF_FFF8;
    desc_address = 64'hDEAD_BEEF_0000_1234;
    desc_length  = 16'h8;
    desc_int     = 1'b1;
    desc_last    = 1'b0;
    desc_push    = 1'b1;
    tick();
    show("t6a0", 64'h4,  32'h0008_0015); tick();
    show("t6a1", 64'h8,  32'h0000_1234); tick();
    show("t6a2", 64'hC,  32'hDEAD_BEEF); tick();
    idle("t6a", 16'd2); tick();
    show("t6b0", 64'h10, 32'h0008_0015); tick();
    show("t6b1", 64'h14, 32'h0000_1234); tick();
    show("t6b2", 64'h18, 32'hDEAD_BEEF); tick();
    show("t6l0", 64'h1C, 32'h0000_0031); tick();
    show("t6l1", 64'h20, 32'hFFFF_FFF8); tick();
    show("t6l2", 64'h24, 32'hFFFF_FFFF); tick();
    idle("t6b", 16'd0); tick();
    desc_push = 1'b0;
    show("t6c0", 64'hFFFF_FFFF_FFFF_FFF8, 32'h0008_0015); tick();
    show("t6c1", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_1234); tick();
    show("t6c2", 64'h0,                   32'hDEAD_BEEF); tick();
    idle("t6c", 16'd1); tick();
    idle("t6d", 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
